// File: rtl/rr_dec_index_gen_if.sv
// Handshake bundle between the round-robin index generator and its
// requester/consumer side: request vector and enable in, binary grant
// index with valid/ack out, plus pointer and timeout observability.
interface rr_dec_index_gen_if #(
    parameter int NREQ  = 16,
    parameter int IDX_W = 4
);
    logic             en;
    logic [NREQ-1:0]  req;
    logic             gnt_ack;
    logic [IDX_W-1:0] gnt_idx;
    logic             gnt_vld;
    logic [IDX_W-1:0] ptr;
    logic             to_err;

    // Requester/consumer side drives requests and acks.
    modport master (
        output en, req, gnt_ack,
        input  gnt_idx, gnt_vld, ptr, to_err
    );

    // Arbiter side issues the grant.
    modport slave (
        input  en, req, gnt_ack,
        output gnt_idx, gnt_vld, ptr, to_err
    );
endinterface

// File: rtl/rr_dec_index_gen.sv
// Round-robin arbiter front-end for a 4:16 decoder. Picks one of 16
// requesters starting at a rotating priority pointer, holds the binary
// index with gnt_vld until ack, and force-releases a grant that has not
// been acknowledged within TIMEOUT cycles (flagged by a to_err pulse).
// All outputs come straight from flops.
module rr_dec_index_gen #(
    parameter int NREQ    = 16,
    parameter int IDX_W   = 4,
    parameter int TIMEOUT = 15,
    parameter int TO_W    = 8
) (
    input  logic           clk,
    input  logic           rst,
    rr_dec_index_gen_if.slave bus
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q,   idx_d;
    logic             vld_q,   vld_d;
    logic [IDX_W-1:0] ptr_q,   ptr_d;
    logic             err_q,   err_d;
    logic [TO_W-1:0]  cnt_q,   cnt_d;

    logic [IDX_W-1:0] pick_idx;
    logic             pick_vld;
    logic [IDX_W-1:0] cand;

    // Find the first requester at or after ptr, wrapping modulo NREQ.
    // Scanning from the farthest offset down lets the nearest hit win.
    always_comb begin
        // NOTE: every variable assigned in always_comb gets a default first;
        // a path that leaves one unassigned would infer a latch.
        pick_vld = 1'b0;
        pick_idx = ptr_q;
        cand     = ptr_q;
        for (int i = NREQ - 1; i >= 0; i--) begin
            cand = ptr_q + IDX_W'(i);
            if (bus.req[cand]) begin
                pick_vld = 1'b1;
                pick_idx = cand;
            end
        end
    end

    // Next-state and next-output logic for the IDLE/GRANT machine.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        vld_d   = vld_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.en && pick_vld) begin
                    state_d = GRANT;
                    idx_d   = pick_idx;
                    vld_d   = 1'b1;
                    cnt_d   = '0;
                end
            end
            GRANT: begin
                if (bus.gnt_ack || (cnt_q == TO_W'(TIMEOUT - 1))) begin
                    // Release: the granted requester drops to lowest priority.
                    state_d = IDLE;
                    vld_d   = 1'b0;
                    ptr_d   = idx_q + IDX_W'(1);
                    err_d   = ~bus.gnt_ack;
                end else begin
                    cnt_d = cnt_q + TO_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            vld_q   <= 1'b0;
            ptr_q   <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            vld_q   <= vld_d;
            ptr_q   <= ptr_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.gnt_idx = idx_q;
    assign bus.gnt_vld = vld_q;
    assign bus.ptr     = ptr_q;
    assign bus.to_err  = err_q;

endmodule

// File: tb/tb_rr_dec_index_gen.sv
// Self-checking bench for rr_dec_index_gen: directed scenarios followed by
// randomized traffic, all compared against a cycle-level reference model
// built from the arbitration rules (modular search, hold until ack or
// timeout, pointer advance on release).
module tb_rr_dec_index_gen;

    localparam int TIMEOUT = 15;

    logic clk;
    logic rst;

    rr_dec_index_gen_if #(.NREQ(16), .IDX_W(4)) bus ();

    rr_dec_index_gen #(
        .NREQ(16), .IDX_W(4), .TIMEOUT(TIMEOUT), .TO_W(8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model state.
    int m_idx, m_ptr, m_cnt;
    bit m_vld, m_err;

    // Model of one clock edge, from the arbitration rules.
    function automatic void model_edge(bit r, bit en, logic [15:0] req, bit ack);
        if (r) begin
            m_idx = 0; m_ptr = 0; m_cnt = 0; m_vld = 0; m_err = 0;
            return;
        end
        m_err = 0;
        if (!m_vld) begin
            if (en && req != 16'h0) begin
                for (int off = 0; off < 16; off++) begin
                    if (req[(m_ptr + off) % 16]) begin
                        m_idx = (m_ptr + off) % 16;
                        break;
                    end
                end
                m_vld = 1;
                m_cnt = 0;
            end
        end else if (ack) begin
            m_vld = 0;
            m_ptr = (m_idx + 1) % 16;
        end else if (m_cnt == TIMEOUT - 1) begin
            m_vld = 0;
            m_ptr = (m_idx + 1) % 16;
            m_err = 1;
        end else begin
            m_cnt++;
        end
    endfunction

    // Drive inputs, advance one edge, update the model, settle past the edge.
    task automatic tick(bit en, logic [15:0] req, bit ack);
        bus.en      = en;
        bus.req     = req;
        bus.gnt_ack = ack;
        @(posedge clk);
        model_edge(rst, en, req, ack);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(1'b0, 16'h0, 1'b0);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({bus.gnt_vld, bus.gnt_idx, bus.ptr, bus.to_err} !== 10'h0) begin
            failures++;
            $display("FAIL reset: got vld=%0b idx=%0d ptr=%0d err=%0b, want all 0",
                     bus.gnt_vld, bus.gnt_idx, bus.ptr, bus.to_err);
        end
    endtask

    task automatic test_single();
        tick(1'b1, 16'h0001, 1'b0);
        checks++;
        if (bus.gnt_vld !== 1'b1 || bus.gnt_idx !== 4'd0) begin
            failures++;
            $display("FAIL single_grant: got vld=%0b idx=%0d, want vld=1 idx=0",
                     bus.gnt_vld, bus.gnt_idx);
        end
        tick(1'b1, 16'h0001, 1'b1);
        checks++;
        if (bus.gnt_vld !== 1'b0 || bus.ptr !== 4'd1) begin
            failures++;
            $display("FAIL single_ack: got vld=%0b ptr=%0d, want vld=0 ptr=1",
                     bus.gnt_vld, bus.ptr);
        end
    endtask

    task automatic test_wrap();
        tick(1'b1, 16'h8001, 1'b0);
        checks++;
        if (bus.gnt_vld !== 1'b1 || bus.gnt_idx !== 4'd15) begin
            failures++;
            $display("FAIL wrap_grant: got vld=%0b idx=%0d, want vld=1 idx=15",
                     bus.gnt_vld, bus.gnt_idx);
        end
        tick(1'b1, 16'h8001, 1'b1);
        checks++;
        if (bus.gnt_vld !== 1'b0 || bus.ptr !== 4'd0) begin
            failures++;
            $display("FAIL wrap_ptr: got vld=%0b ptr=%0d, want vld=0 ptr=0",
                     bus.gnt_vld, bus.ptr);
        end
        tick(1'b1, 16'h8001, 1'b0);
        checks++;
        if (bus.gnt_vld !== 1'b1 || bus.gnt_idx !== 4'd0) begin
            failures++;
            $display("FAIL wrap_regrant: got vld=%0b idx=%0d, want vld=1 idx=0",
                     bus.gnt_vld, bus.gnt_idx);
        end
        tick(1'b0, 16'h0, 1'b1);
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int k = 0; k <= 16; k++) begin
            tick(1'b1, 16'hFFFF, 1'b1);
            checks++;
            if (bus.gnt_vld !== 1'b1 || bus.gnt_idx !== 4'(k % 16)) begin
                failures++;
                $display("FAIL rr_grant[%0d]: got vld=%0b idx=%0d, want vld=1 idx=%0d",
                         k, bus.gnt_vld, bus.gnt_idx, k % 16);
            end
            tick(1'b1, 16'hFFFF, 1'b1);
            checks++;
            if (bus.gnt_vld !== 1'b0 || bus.ptr !== 4'((k + 1) % 16)) begin
                failures++;
                $display("FAIL rr_gap[%0d]: got vld=%0b ptr=%0d, want vld=0 ptr=%0d",
                         k, bus.gnt_vld, bus.ptr, (k + 1) % 16);
            end
        end
    endtask

    task automatic test_sticky();
        do_reset();
        tick(1'b1, 16'h0020, 1'b0);
        for (int k = 0; k < 6; k++) begin
            tick(1'($urandom_range(0, 1)), (k == 0) ? 16'h0 : 16'($urandom), 1'b0);
            checks++;
            if (bus.gnt_vld !== 1'b1 || bus.gnt_idx !== 4'd5) begin
                failures++;
                $display("FAIL sticky[%0d]: got vld=%0b idx=%0d, want vld=1 idx=5",
                         k, bus.gnt_vld, bus.gnt_idx);
            end
        end
        tick(1'b0, 16'h0, 1'b1);
        checks++;
        if (bus.gnt_vld !== 1'b0 || bus.ptr !== 4'd6 || bus.to_err !== 1'b0) begin
            failures++;
            $display("FAIL sticky_ack: got vld=%0b ptr=%0d err=%0b, want vld=0 ptr=6 err=0",
                     bus.gnt_vld, bus.ptr, bus.to_err);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        tick(1'b1, 16'h0008, 1'b0);
        for (int k = 1; k <= TIMEOUT; k++) begin
            tick(1'b1, 16'($urandom), 1'b0);
            checks++;
            if (k < TIMEOUT && (bus.gnt_vld !== 1'b1 || bus.to_err !== 1'b0)) begin
                failures++;
                $display("FAIL timeout_hold[%0d]: got vld=%0b err=%0b, want vld=1 err=0",
                         k, bus.gnt_vld, bus.to_err);
            end else if (k == TIMEOUT &&
                         (bus.gnt_vld !== 1'b0 || bus.to_err !== 1'b1 || bus.ptr !== 4'd4)) begin
                failures++;
                $display("FAIL timeout_release: got vld=%0b err=%0b ptr=%0d, want vld=0 err=1 ptr=4",
                         bus.gnt_vld, bus.to_err, bus.ptr);
            end
        end
        tick(1'b0, 16'h0, 1'b0);
        checks++;
        if (bus.to_err !== 1'b0) begin
            failures++;
            $display("FAIL timeout_pulse: got err=%0b, want 0", bus.to_err);
        end
    endtask

    task automatic test_ack_on_timeout();
        do_reset();
        tick(1'b1, 16'h0100, 1'b0);
        for (int k = 1; k < TIMEOUT; k++) tick(1'b1, 16'h0100, 1'b0);
        tick(1'b1, 16'h0100, 1'b1);
        checks++;
        if (bus.gnt_vld !== 1'b0 || bus.to_err !== 1'b0 || bus.ptr !== 4'd9) begin
            failures++;
            $display("FAIL ack_on_timeout: got vld=%0b err=%0b ptr=%0d, want vld=0 err=0 ptr=9",
                     bus.gnt_vld, bus.to_err, bus.ptr);
        end
    endtask

    task automatic test_reset_mid_grant();
        do_reset();
        tick(1'b1, 16'h0200, 1'b0);
        tick(1'b1, 16'h0200, 1'b0);
        checks++;
        if (bus.gnt_vld !== 1'b1 || bus.gnt_idx !== 4'd9) begin
            failures++;
            $display("FAIL mid_grant_setup: got vld=%0b idx=%0d, want vld=1 idx=9",
                     bus.gnt_vld, bus.gnt_idx);
        end
        do_reset();
        checks++;
        if ({bus.gnt_vld, bus.gnt_idx, bus.ptr, bus.to_err} !== 10'h0) begin
            failures++;
            $display("FAIL mid_grant_reset: got vld=%0b idx=%0d ptr=%0d err=%0b, want all 0",
                     bus.gnt_vld, bus.gnt_idx, bus.ptr, bus.to_err);
        end
        for (int k = 0; k < 3; k++) begin
            tick(1'b0, 16'hFFFF, 1'($urandom_range(0, 1)));
            checks++;
            if (bus.gnt_vld !== 1'b0) begin
                failures++;
                $display("FAIL en_low[%0d]: got vld=%0b, want 0", k, bus.gnt_vld);
            end
        end
    endtask

    task automatic test_random();
        logic [15:0] req;
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            case ($urandom_range(0, 3))
                0:       req = 16'h0;
                1:       req = 16'(1 << $urandom_range(0, 15));
                default: req = 16'($urandom);
            endcase
            rst = ($urandom_range(0, 199) == 0);
            tick($urandom_range(0, 4) != 0, req, $urandom_range(0, 7) == 0);
            rst = 1'b0;
            checks++;
            if (bus.gnt_vld !== m_vld || bus.gnt_idx !== 4'(m_idx) ||
                bus.ptr !== 4'(m_ptr) || bus.to_err !== m_err) begin
                failures++;
                $display("FAIL random[%0d]: got vld=%0b idx=%0d ptr=%0d err=%0b, want vld=%0b idx=%0d ptr=%0d err=%0b",
                         k, bus.gnt_vld, bus.gnt_idx, bus.ptr, bus.to_err,
                         m_vld, m_idx, m_ptr, m_err);
            end
        end
    endtask

    initial begin
        rst         = 1'b1;
        bus.en      = 1'b0;
        bus.req     = '0;
        bus.gnt_ack = 1'b0;
        m_idx = 0; m_ptr = 0; m_cnt = 0; m_vld = 0; m_err = 0;
        test_reset();
        test_single();
        test_wrap();
        test_round_robin();
        test_sticky();
        test_timeout();
        test_ack_on_timeout();
        test_reset_mid_grant();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
